// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction fetch sequencer. A three-state machine (IDLE -> FETCH -> ISSUE)
// fetches one instruction word from instruction memory, hands it to the
// datapath, then computes the next fetch address from the redirect requests
// that are presented while the instruction is being issued.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request (high for every FETCH cycle)
//   imem_addr    fetch address, held stable while a request is outstanding
//   imem_ack     memory accepts the request; imem_rdata is valid that cycle
//   imem_rdata   fetched instruction word
//   instr_valid  instruction presented to the datapath (ISSUE state)
//   instr_out    issued instruction word
//   instr_pc     address of the issued instruction
//   stall        datapath not ready; the issued instruction is held
//   jr/jr_addr   register-indirect jump (highest priority)
//   jump/jump_index    region-relative absolute jump
//   br_taken/br_imm    PC-relative branch, word offset
//   misalign_err one-cycle pulse when a JR target is not word aligned
//
// Throughput is one instruction every two cycles when memory acknowledges
// in the same cycle as the request.
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] br_tgt_s;
  logic [31:0] next_pc_s;
  logic        jr_bad_s;

  // Branch immediate is a signed word offset: sign-extend and scale to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Next-PC selection for the instruction currently in ISSUE.
  // Priority: jr > jump > br_taken > sequential. A misaligned JR target is
  // not followed; execution falls through to the sequential address.
  always_comb begin
    pc_plus4_s = instr_pc + 32'd4;
    jump_tgt_s = {pc_plus4_s[31:28], jump_index, 2'b00};
    br_tgt_s   = pc_plus4_s + branch_offset(br_imm);
    jr_bad_s   = 1'b0;
    next_pc_s  = pc_plus4_s;
    if (jr) begin
      if (jr_addr[1:0] == 2'b00) begin
        next_pc_s = jr_addr;
      end else begin
        next_pc_s = pc_plus4_s;
        jr_bad_s  = 1'b1;
      end
    end else if (jump) begin
      next_pc_s = jump_tgt_s;
    end else if (br_taken) begin
      next_pc_s = br_tgt_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Sequencer state machine with all outputs registered.
  // imem_req is raised on the edge that enters FETCH, so the first request
  // after reset is seen by memory on the second rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_out    <= 32'h0000_0000;
      instr_pc     <= 32'h0000_0000;
      misalign_err <= 1'b0;
    end else begin
      // Error is a pulse: cleared every cycle unless set below.
      misalign_err <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r     <= FETCH;
          imem_req    <= 1'b1;
          imem_addr   <= pc_r;
          instr_valid <= 1'b0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_out   <= imem_rdata;
            instr_pc    <= pc_r;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            // Keep requesting the same address until memory accepts.
            imem_req    <= 1'b1;
            imem_addr   <= pc_r;
            instr_valid <= 1'b0;
            state_r     <= FETCH;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc_r         <= next_pc_s;
            imem_addr    <= next_pc_s;
            imem_req     <= 1'b1;
            instr_valid  <= 1'b0;
            misalign_err <= jr_bad_s;
            state_r      <= FETCH;
          end else begin
            // Hold the instruction; redirect inputs are not looked at.
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state_r     <= ISSUE;
          end
        end
        default: begin
          state_r     <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Scoreboard bench for pc_sequencer. The driver pushes every expected fetch
// address into fetch_q at the moment it drives the stimulus that causes it.
// A negedge monitor pops fetch_q on each accepted fetch and, in turn, queues
// the expected (pc, instruction) pair that must appear on the next issue.
// Instruction memory is modelled as imem_rdata = imem_addr ^ KEY.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] KEY = 32'hC3A5_5A3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        stall;
  logic        jr;
  logic [31:0] jr_addr;
  logic        jump;
  logic [25:0] jump_index;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } iss_t;

  logic [31:0] fetch_q[$];
  iss_t        iss_q[$];
  logic [31:0] model_pc;
  logic        prev_valid = 1'b0;
  int          mis_seen = 0;
  int          mis_exp = 0;
  int          total = 0;
  int          bad = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .stall(stall), .jr(jr), .jr_addr(jr_addr), .jump(jump),
    .jump_index(jump_index), .br_taken(br_taken), .br_imm(br_imm),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: accepted fetches and newly issued instructions.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        chk("fetch_pending", 32'(fetch_q.size() != 0), 32'd1);
        if (fetch_q.size() != 0) begin
          chk("imem_addr", imem_addr, fetch_q[0]);
          iss_q.push_back('{fetch_q[0], fetch_q[0] ^ KEY});
          void'(fetch_q.pop_front());
        end
      end
      if (instr_valid && !prev_valid) begin
        chk("issue_pending", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          chk("instr_pc", instr_pc, iss_q[0].pc);
          chk("instr_out", instr_out, iss_q[0].ins);
          void'(iss_q.pop_front());
        end
      end
      if (misalign_err) mis_seen <= mis_seen + 1;
      prev_valid <= instr_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("issue_timeout", 32'(instr_valid), 32'd1);
  endtask

  // Issue one instruction: optional stall cycles with jump toggling, then
  // release with the given redirect inputs and queue the expected target.
  task automatic issue(input logic j_r, input logic [31:0] ja, input logic j,
                       input logic [25:0] ji, input logic b, input logic [15:0] bi,
                       input int stalls);
    logic [31:0] cur;
    logic [31:0] p4;
    logic [31:0] nxt;
    logic        mis;
    wait_issue();
    cur = model_pc;
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      jump       = ~jump;
      jump_index = 26'($urandom);
      tick();
      chk("stall_pc", instr_pc, cur);
      chk("stall_instr", instr_out, cur ^ KEY);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    p4  = cur + 32'd4;
    mis = 1'b0;
    if (j_r) begin
      if (ja[1:0] == 2'b00) nxt = ja;
      else begin
        nxt = p4;
        mis = 1'b1;
      end
    end else if (j) nxt = {p4[31:28], ji, 2'b00};
    else if (b) nxt = p4 + 32'(int'($signed(bi)) * 4);
    else nxt = p4;
    jr = j_r; jr_addr = ja; jump = j; jump_index = ji;
    br_taken = b; br_imm = bi; stall = 1'b0;
    fetch_q.push_back(nxt);
    model_pc = nxt;
    if (mis) mis_exp++;
    tick();
    stall = 1'b1; jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
    chk("misalign_err", 32'(misalign_err), 32'(mis));
    chk("req_after_issue", 32'(imem_req), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0000_0000);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr_out, 32'h0000_0000);
    chk({tag, "_pc"}, instr_pc, 32'h0000_0000);
    chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b1;
    jr = 1'b0; jr_addr = 32'h0; jump = 1'b0; jump_index = 26'h0;
    br_taken = 1'b0; br_imm = 16'h0; model_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    imem_ack = 1'b1;
    tick();
    chk("rst_ack_ignored", 32'(imem_req), 32'd0);

    // Reset release, ack tied high, no redirects: 0x0, 0x4, 0x8.
    fetch_q.push_back(32'h0000_0000);
    fetch_q.push_back(32'h0000_0004);
    fetch_q.push_back(32'h0000_0008);
    stall = 1'b0;
    rst_n = 1'b1;
    chk("req_before_edge1", 32'(imem_req), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("seq_valid", 32'(instr_valid), 32'(k % 2 == 0));
      chk("seq_req", 32'(imem_req), 32'(k % 2 == 1));
    end
    stall = 1'b1;
    model_pc = 32'h0000_0008;

    // Jump target within the current 256 MB region.
    issue(1'b1, 32'h1000_0010, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    issue(1'b0, 32'h0, 1'b1, 26'h0000100, 1'b0, 16'h0, 0);
    chk("jump_target", imem_addr, 32'h1000_0400);

    // Backward branch, then jump beating branch in the same cycle.
    issue(1'b1, 32'h0000_0040, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFE, 0);
    chk("branch_target", imem_addr, 32'h0000_003C);
    issue(1'b1, 32'h0000_0040, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    issue(1'b0, 32'h0, 1'b1, 26'h0000123, 1'b1, 16'hFFFE, 0);
    chk("jump_over_branch", imem_addr, 32'h0000_048C);
    issue(1'b1, 32'h0000_3000, 1'b1, 26'h0000123, 1'b1, 16'h0010, 0);
    chk("jr_over_all", imem_addr, 32'h0000_3000);

    // Misaligned JR falls through; aligned JR is followed.
    issue(1'b1, 32'h0000_2002, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    chk("jr_misaligned", imem_addr, 32'h0000_3004);
    issue(1'b1, 32'h0000_2000, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    chk("jr_aligned", imem_addr, 32'h0000_2000);

    // Stall with toggling jump: only the release cycle counts.
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 3);
    chk("stall_seq", imem_addr, 32'h0000_2004);
    issue(1'b0, 32'h0, 1'b1, 26'h0000ABC, 1'b0, 16'h0, 3);
    chk("stall_jump", imem_addr, 32'h0000_2AF0);

    // Address wrap-around, both sequential and via a backward branch.
    issue(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    chk("seq_wrap", imem_addr, 32'h0000_0000);
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFE, 0);
    chk("branch_wrap", imem_addr, 32'hFFFF_FFFC);

    // Ack withheld, then reset mid-FETCH and refetch from RESET_PC.
    wait_issue();
    imem_ack = 1'b0;
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wait_addr", imem_addr, model_pc);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    fetch_q.delete();
    iss_q.delete();
    imem_ack = 1'b1;
    tick();
    tick();
    chk("midrst_hold_req", 32'(imem_req), 32'd0);
    fetch_q.push_back(32'h0000_0000);
    model_pc = 32'h0000_0000;
    rst_n = 1'b1;
    tick();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h0000_0000);
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    issue(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 0);
    wait_issue();
    repeat (2) tick();

    chk("fetch_q_left", 32'(fetch_q.size()), 32'd0);
    chk("iss_q_left", 32'(iss_q.size()), 32'd0);
    chk("misalign_count", 32'(mis_seen), 32'(mis_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: imem_req  out  1  instruction-memory fetch request.
REQ-005 SHALL have port: imem_addr  out  32  fetch address.
REQ-006 SHALL have port: imem_ack  in  1  memory accepts request; instr valid same cycle.
REQ-007 SHALL have port: imem_rdata  in  32  fetched instruction word.
REQ-008 SHALL have ports: instr_valid  out  1; instr_out  out  32; instr_pc  out  32: instruction handed to the datapath.
REQ-009 SHALL have port: stall  in  1  datapath not ready; hold current instruction.
REQ-010 SHALL have ports: jr  in  1; jr_addr  in  32; jump  in  1; jump_index  in  26; br_taken  in  1; br_imm  in  16: redirect requests, sampled only on ISSUE with stall=0.
REQ-011 SHALL have port: misalign_err  out  1  one-cycle pulse on misaligned JR target.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, ISSUE.
REQ-013 SHALL, in IDLE (one cycle after reset release), transition unconditionally to FETCH.
REQ-014 SHALL, in FETCH: drive imem_req=1, imem_addr=pc; on imem_ack=1 capture imem_rdata into instr_out, pc into instr_pc, go to ISSUE; otherwise remain in FETCH with imem_addr held stable.
REQ-015 SHALL, in ISSUE: drive instr_valid=1, imem_req=0; with stall=1, remain in ISSUE with instr_out/instr_pc unchanged and redirect inputs ignored.
REQ-016 SHALL, in ISSUE with stall=0: load pc with next-PC and return to FETCH.
REQ-017 SHALL compute next-PC with priority jr > jump > br_taken > sequential; simultaneous requests resolve by this priority only.
REQ-018 SHALL compute sequential PC as pc_plus4 = instr_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 SHALL compute jump target as {pc_plus4[31:28], jump_index, 2'b00}.
REQ-020 SHALL compute branch target as pc_plus4 + (sign-extended br_imm shifted left 2), modulo 2^32.
REQ-021 SHALL load jr_addr unchanged when jr_addr[1:0]==0; otherwise load pc_plus4 and pulse misalign_err for exactly the cycle after the ISSUE cycle.
REQ-022 SHALL register all outputs; minimum throughput one instruction per 2 cycles (FETCH with same-cycle ack, then ISSUE).
REQ-023 SHALL drive instr_valid=0 in IDLE and FETCH.

Reset
REQ-024 SHALL, on rst_n=0 (any state, incl. mid-FETCH), asynchronously set state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, misalign_err=0.
REQ-025 SHALL abandon any outstanding fetch on reset; an imem_ack arriving while rst_n=0 is ignored.
REQ-026 SHALL issue first imem_req with imem_addr=RESET_PC in the second rising edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: reset release, imem_ack tied 1, no redirects -> imem_addr sequence 0x0, 0x4, 0x8 with instr_valid every 2nd cycle.
REQ-028 SHALL cover: instr_pc=0x1000_0010, jump=1, jump_index=0x0000100 -> next imem_addr=0x1000_0400.
REQ-029 SHALL cover: instr_pc=0x0000_0040, br_taken=1, br_imm=16'hFFFE -> next imem_addr=0x0000_003C; same cycle jump=1 -> jump target wins.
REQ-030 SHALL cover: jr=1, jr_addr=0x0000_2002 -> misalign_err pulses once, next imem_addr=instr_pc+4; jr_addr=0x0000_2000 -> next imem_addr=0x0000_2000, no error.
REQ-031 SHALL cover: stall held 3 cycles in ISSUE with jump=1 toggling -> instr_out/instr_pc stable, no imem_req, redirect taken only from stall-release cycle.
REQ-032 SHALL cover: imem_ack withheld 4 cycles then rst_n pulsed low mid-FETCH -> imem_addr stable while waiting, all outputs at reset values, refetch from RESET_PC.
